// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide responder on the mdc command bus.
// Single-cycle mult/multu and a WIDTH-step restoring divider for div/divu.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mdc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mul_result,
    output logic             busy
);
    // state | meaning
    // IDLE  | accepts mdc commands; mult/mthi/mtlo complete here
    // RUN   | one restoring divide step per cycle, WIDTH cycles
    // DONE  | results written, stalled div still on mdc is ignored
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] MDC_MULT  = 3'd1;
    localparam logic [2:0] MDC_MULTU = 3'd2;
    localparam logic [2:0] MDC_DIV   = 3'd3;
    localparam logic [2:0] MDC_DIVU  = 3'd4;
    localparam logic [2:0] MDC_MTHI  = 3'd5;
    localparam logic [2:0] MDC_MTLO  = 3'd6;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    count;
    logic             sign_q;
    logic             sign_r;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     rem_shift;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quot_next;
    logic               is_div;

    assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign mul_result = prod_u[WIDTH-1:0];

    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // Extra top bit keeps the compare exact when divisor exceeds 2^(WIDTH-1).
    assign rem_shift = {rem, dvd[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, divisor};
    assign rem_next  = rem_ge ? (rem_shift[WIDTH-1:0] - divisor) : rem_shift[WIDTH-1:0];
    assign quot_next = {dvd[WIDTH-2:0], rem_ge};

    assign is_div = (mdc == MDC_DIV) || (mdc == MDC_DIVU);
    assign busy   = !rst && (((state == IDLE) && is_div) || (state == RUN));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            dvd     <= '0;
            divisor <= '0;
            rem     <= '0;
            count   <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    case (mdc)
                        MDC_MULT:  {hi, lo} <= prod_s;
                        MDC_MULTU: {hi, lo} <= prod_u;
                        MDC_MTHI:  hi <= a;
                        MDC_MTLO:  lo <= a;
                        MDC_DIV, MDC_DIVU: begin
                            // Zero divisor: raw a shifts fully into rem, quotient saturates to ones.
                            if (b == '0) begin
                                dvd     <= a;
                                divisor <= '0;
                                sign_q  <= 1'b0;
                                sign_r  <= 1'b0;
                            end else if (mdc == MDC_DIV) begin
                                dvd     <= abs_a;
                                divisor <= abs_b;
                                sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                                sign_r  <= a[WIDTH-1];
                            end else begin
                                dvd     <= a;
                                divisor <= b;
                                sign_q  <= 1'b0;
                                sign_r  <= 1'b0;
                            end
                            rem   <= '0;
                            count <= '0;
                            state <= RUN;
                        end
                        default: ;
                    endcase
                end
                RUN: begin
                    rem   <= rem_next;
                    dvd   <= quot_next;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        lo    <= sign_q ? -quot_next : quot_next;
                        hi    <= sign_r ? -rem_next : rem_next;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
